// File: rtl/ext_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// ext_mem_bus_arbiter
//
// Shares the single external-memory bus (SDRAM controller, SPI flash) between
// NR_MASTERS bus masters. The bus is granted round-robin, one transaction at a
// time. Each transaction is tracked from beginTransaction to endTransaction or
// busError. A watchdog aborts a transaction that stalls by injecting busError
// and endTransaction onto the bus for one cycle.
//
// Ports:
//   clock               system clock (single domain)
//   reset               synchronous, active-high reset
//   requestIn           per-master level request, held until its transaction ends
//   grantOut            registered one-hot grant
//   activeMasterOut     index of the granted master (valid while grantOut != 0)
//   beginTransactionIn  bus beginTransaction
//   endTransactionIn    bus endTransaction
//   dataValidIn         bus dataValid
//   busyIn              bus busy
//   busErrorIn          bus error from any slave
//   endTransactionOut   injected endTransaction on watchdog abort
//   busErrorOut         injected busError on watchdog abort
//   timeoutCountOut     saturating count of watchdog aborts
// -----------------------------------------------------------------------------
module ext_mem_bus_arbiter #(
    parameter int NR_MASTERS     = 4,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TIMEOUT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NR_MASTERS-1:0] requestIn,
    output logic [NR_MASTERS-1:0] grantOut,
    output logic [2:0]            activeMasterOut,
    input  logic                  beginTransactionIn,
    input  logic                  endTransactionIn,
    input  logic                  dataValidIn,
    input  logic                  busyIn,
    input  logic                  busErrorIn,
    output logic                  endTransactionOut,
    output logic                  busErrorOut,
    output logic [15:0]           timeoutCountOut
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        ACTIVE  = 2'd2,
        ABORT   = 2'd3
    } state_t;

    // The abort is taken on the idle cycle that would bring the watchdog to
    // TIMEOUT_CYCLES, so the ABORT cycle follows exactly TIMEOUT_CYCLES idle
    // cycles.
    localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                   state, state_n;
    logic [NR_MASTERS-1:0]    grant_n;
    logic [2:0]               active_n;
    logic [2:0]               last_grant, last_grant_n;
    logic [TIMEOUT_WIDTH-1:0] watchdog, watchdog_n;
    logic                     abort_n;
    logic [15:0]              timeout_count_n;

    // Round-robin pick: first requesting master after last_grant, wrapping.
    logic       found;
    logic [2:0] sel;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 1; i <= NR_MASTERS; i++) begin
            int cand;
            cand = int'(last_grant) + i;
            if (cand >= NR_MASTERS) begin
                cand = cand - NR_MASTERS;
            end
            if (!found && ((requestIn & (NR_MASTERS'(1) << cand)) != '0)) begin
                found = 1'b1;
                sel   = 3'(cand);
            end
        end
    end

    // Active master's request is still up; grantOut is one-hot on that master.
    logic active_requesting;
    assign active_requesting = (requestIn & grantOut) != '0;

    // Bus is silent this cycle from the watchdog's point of view.
    logic bus_quiet;
    assign bus_quiet = !(dataValidIn || busyIn || endTransactionIn || busErrorIn);

    // NOTE: every signal gets a default before the case so that no path leaves
    // it unassigned; an unassigned path would infer a latch.
    always_comb begin
        state_n         = state;
        grant_n         = grantOut;
        active_n        = activeMasterOut;
        last_grant_n    = last_grant;
        watchdog_n      = watchdog;
        abort_n         = 1'b0;
        timeout_count_n = timeoutCountOut;

        unique case (state)
            IDLE: begin
                // beginTransactionIn here is a protocol violation and ignored.
                if (found) begin
                    grant_n      = NR_MASTERS'(1) << sel;
                    active_n     = sel;
                    last_grant_n = sel;
                    state_n      = GRANTED;
                end
            end

            GRANTED: begin
                // busErrorIn and other masters' requests are ignored here.
                if (beginTransactionIn) begin
                    watchdog_n = '0;
                    state_n    = ACTIVE;
                end else if (!active_requesting) begin
                    grant_n = '0;
                    state_n = IDLE;
                end
            end

            ACTIVE: begin
                // A normal end beats a watchdog expiring on the same cycle.
                if (endTransactionIn || busErrorIn) begin
                    grant_n = '0;
                    state_n = IDLE;
                end else if (!bus_quiet) begin
                    watchdog_n = '0;
                end else if (watchdog == WD_LAST) begin
                    watchdog_n = watchdog + 1'b1;
                    abort_n    = 1'b1;
                    state_n    = ABORT;
                    if (timeoutCountOut != 16'hFFFF) begin
                        timeout_count_n = timeoutCountOut + 16'd1;
                    end
                end else begin
                    watchdog_n = watchdog + 1'b1;
                end
            end

            ABORT: begin
                // Grant stays up during the abort cycle, released afterwards.
                grant_n = '0;
                state_n = IDLE;
            end

            default: begin
                grant_n = '0;
                state_n = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same clock edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            grantOut          <= '0;
            activeMasterOut   <= '0;
            last_grant        <= 3'(NR_MASTERS - 1);
            watchdog          <= '0;
            endTransactionOut <= 1'b0;
            busErrorOut       <= 1'b0;
            timeoutCountOut   <= '0;
        end else begin
            state             <= state_n;
            grantOut          <= grant_n;
            activeMasterOut   <= active_n;
            last_grant        <= last_grant_n;
            watchdog          <= watchdog_n;
            endTransactionOut <= abort_n;
            busErrorOut       <= abort_n;
            timeoutCountOut   <= timeout_count_n;
        end
    end

endmodule
